imem_run_controller: RTL and testbench

//  Owns the single instruction-memory port; shares it between the host program loader and the fetch stage.

---
 rtl/imem_run_controller.sv | 160 ++++++++++++++++
 tb/tb_imem_run_controller.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_run_controller.sv
// imem_run_controller
//   Owns the single IMEM port and shares it between the host program loader
//   (IDLE/DONE) and the fetch stage (START/RUN). Sequences load -> start ->
//   run -> halt, issues the one-cycle fetch start pulse, detects the HALT
//   opcode on the synchronous read data and counts run cycles with a
//   saturating watchdog.
//
//   Host write handshake: a write transfers on every rising edge where
//   host_wr_valid && host_wr_ready are both high. host_wr_ready depends only
//   on the FSM state (high in IDLE and DONE), never on host_wr_valid, so the
//   write reaches the IMEM in the same cycle with no added latency. While the
//   fetch stage owns the port, ready is low and the host must hold its request.
module imem_run_controller #(
   parameter int               IMEM_DEPTH = 2048,
   parameter logic [3:0]       HALT_OPC   = 4'b1010,
   parameter int               CNT_W      = 32,
   parameter logic [CNT_W-1:0] MAX_CYCLES = {CNT_W{1'b1}},
   localparam int              AW         = $clog2(2*IMEM_DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             host_wr_valid,
   output logic             host_wr_ready,
   input  logic [AW-1:0]    host_wr_addr,
   input  logic [15:0]      host_wr_data,
   input  logic             host_run,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] run_cycles,
   output logic             fetch_start,
   input  logic [AW-1:0]    fetch_addr,
   output logic             mem_en,
   output logic             mem_we,
   output logic [AW-1:0]    mem_addr,
   output logic [15:0]      mem_din,
   input  logic [15:0]      mem_dout,
   output logic [1:0]       fsm_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t state;
   state_t state_nxt;

   // First RUN cycle sees read data addressed during START, so it is masked.
   logic chk_valid;
   logic halt_hit;
   logic wd_hit;

   // Only the opcode nibble of the read data matters to the controller.
   logic unused_dout_hi;
   assign unused_dout_hi = ^mem_dout[15:4];

   assign fsm_state = state;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic, IMEM port mux and handshake outputs.
   always_comb begin
      state_nxt     = state;
      host_wr_ready = 1'b0;
      busy          = 1'b0;
      fetch_start   = 1'b0;
      mem_en        = 1'b1;
      mem_addr      = host_wr_addr;
      mem_din       = host_wr_data;
      halt_hit      = 1'b0;
      wd_hit        = 1'b0;
      case (state)
         S_IDLE: begin
            host_wr_ready = 1'b1;
            if (host_run) begin
               state_nxt = S_START;
            end
         end
         S_START: begin
            busy        = 1'b1;
            fetch_start = 1'b1;
            mem_addr    = fetch_addr;
            state_nxt   = S_RUN;
         end
         S_RUN: begin
            busy     = 1'b1;
            mem_addr = fetch_addr;
            halt_hit = chk_valid && (mem_dout[3:0] == HALT_OPC);
            wd_hit   = (run_cycles == MAX_CYCLES);
            if (halt_hit || wd_hit) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            host_wr_ready = 1'b1;
            if (host_run) begin
               state_nxt = S_START;
            end else if (host_wr_valid) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      mem_we = host_wr_valid & host_wr_ready;
   end

   // Run bookkeeping: cycle counter, done/timeout flags and halt-check mask.
   always_ff @(posedge clk) begin
      if (rst) begin
         run_cycles <= '0;
         done       <= 1'b0;
         timeout    <= 1'b0;
         chk_valid  <= 1'b0;
      end else begin
         chk_valid <= (state == S_RUN);
         case (state)
            S_START: begin
               run_cycles <= '0;
               done       <= 1'b0;
               timeout    <= 1'b0;
            end
            S_RUN: begin
               // Saturate at the watchdog limit; never wrap.
               if (!wd_hit) begin
                  run_cycles <= run_cycles + CNT_W'(1);
               end
               if (halt_hit) begin
                  done    <= 1'b1;
                  timeout <= 1'b0;
               end else if (wd_hit) begin
                  done    <= 1'b1;
                  timeout <= 1'b1;
               end
            end
            S_DONE: begin
               // A new program load retires the previous result flags.
               if (host_wr_valid) begin
                  done    <= 1'b0;
                  timeout <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_run_controller.sv
// tb_imem_run_controller
//   Drives the controller with a behavioural IMEM and fetch-stage model.
//   Expected run results come from the program image: the first HALT word
//   position decides the cycle count, otherwise the watchdog limit applies.
module tb_imem_run_controller;

   localparam int         AW    = 12;
   localparam int         CNT_W = 4;
   localparam int         MAXC  = 10;
   localparam logic [3:0] HALT  = 4'hA;

   logic             clk;
   logic             rst;
   logic             host_wr_valid;
   logic             host_wr_ready;
   logic [AW-1:0]    host_wr_addr;
   logic [15:0]      host_wr_data;
   logic             host_run;
   logic             busy;
   logic             done;
   logic             timeout;
   logic [CNT_W-1:0] run_cycles;
   logic             fetch_start;
   logic [AW-1:0]    fetch_addr;
   logic             mem_en;
   logic             mem_we;
   logic [AW-1:0]    mem_addr;
   logic [15:0]      mem_din;
   logic [15:0]      mem_dout;
   logic [1:0]       fsm_state;

   int checks   = 0;
   int failures = 0;

   logic [15:0]  imem    [0:(1<<AW)-1];
   logic [15:0]  exp_mem [0:(1<<AW)-1];
   logic [CNT_W:0] exp_q[$];

   logic [AW-1:0] pc;
   logic          pc_load;
   logic [AW-1:0] pc_load_val;

   imem_run_controller #(
      .CNT_W      (CNT_W),
      .MAX_CYCLES (4'd10)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .host_wr_valid (host_wr_valid),
      .host_wr_ready (host_wr_ready),
      .host_wr_addr  (host_wr_addr),
      .host_wr_data  (host_wr_data),
      .host_run      (host_run),
      .busy          (busy),
      .done          (done),
      .timeout       (timeout),
      .run_cycles    (run_cycles),
      .fetch_start   (fetch_start),
      .fetch_addr    (fetch_addr),
      .mem_en        (mem_en),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_din       (mem_din),
      .mem_dout      (mem_dout),
      .fsm_state     (fsm_state)
   );

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // IMEM macro: read-first, one-cycle synchronous read.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) imem[mem_addr] <= mem_din;
         mem_dout <= imem[mem_addr];
      end
   end

   // Fetch stage: PC restarts at 0 on the start pulse and advances while busy.
   always @(posedge clk) begin
      if (rst || fetch_start) pc <= '0;
      else if (pc_load)       pc <= pc_load_val;
      else if (busy)          pc <= pc + 12'd1;
   end
   assign fetch_addr = pc;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: the first HALT at word h is seen h+2 RUN cycles after START;
   // a HALT seen on the watchdog cycle still wins.
   function automatic void predict(output int nrun, output int rc, output bit to);
      int h;
      h = -1;
      for (int a = 0; a < MAXC; a++)
         if (h < 0 && exp_mem[a][3:0] == HALT) h = a;
      if (h >= 0) begin
         nrun = h + 2;
         rc   = (h + 2 > MAXC) ? MAXC : h + 2;
         to   = 1'b0;
      end else begin
         nrun = MAXC + 1;
         rc   = MAXC;
         to   = 1'b1;
      end
   endfunction

   function automatic logic [15:0] rand_word();
      logic [15:0] w;
      w = 16'($urandom);
      if ($urandom_range(0, 3) == 0) w[3:0] = HALT;
      return w;
   endfunction

   task automatic write_word(input logic [AW-1:0] a, input logic [15:0] d);
      @(negedge clk);
      host_run      = 1'b0;
      host_wr_valid = 1'b1;
      host_wr_addr  = a;
      host_wr_data  = d;
      #1;
      check_eq("wr_ready", host_wr_ready, 1);
      check_eq("wr_we",    mem_we,        1);
      check_eq("wr_addr",  mem_addr,      a);
      check_eq("wr_din",   mem_din,       d);
      exp_mem[a] = d;
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      host_wr_valid = 1'b0;
      host_run      = 1'b0;
      #1;
      check_eq("idle_busy", busy, 0);
      check_eq("idle_done", done, 0);
      check_eq("idle_to",   timeout, 0);
      check_eq("idle_rdy",  host_wr_ready, 1);
   endtask

   task automatic preload_pc(input logic [AW-1:0] v);
      @(negedge clk);
      host_wr_valid = 1'b0;
      pc_load       = 1'b1;
      pc_load_val   = v;
      @(negedge clk);
      pc_load       = 1'b0;
   endtask

   // Launch a run (optionally with a same-cycle write) and follow it to DONE.
   task automatic run_prog(input string tag, input bit spur, input bit wr_too,
                           input logic [AW-1:0] wa, input logic [15:0] wd);
      int nrun;
      int rc;
      bit exp_to;
      logic [CNT_W:0] exp_res;
      @(negedge clk);
      host_run      = 1'b1;
      host_wr_valid = wr_too;
      host_wr_addr  = wa;
      host_wr_data  = wd;
      #1;
      check_eq({tag, "_rdy_at_run"}, host_wr_ready, 1);
      check_eq({tag, "_we_at_run"},  mem_we,        wr_too);
      if (wr_too) exp_mem[wa] = wd;
      predict(nrun, rc, exp_to);
      exp_q.push_back({exp_to, CNT_W'(rc)});
      @(negedge clk);
      host_run      = 1'b0;
      host_wr_valid = 1'b0;
      #1;
      check_eq({tag, "_start_pulse"}, fetch_start, 1);
      check_eq({tag, "_start_busy"},  busy,        1);
      check_eq({tag, "_start_rdy"},   host_wr_ready, 0);
      for (int i = 1; i <= nrun; i++) begin
         @(negedge clk);
         host_wr_valid = spur && ($urandom_range(0, 1) == 1);
         host_wr_addr  = 12'($urandom_range(0, 15));
         host_wr_data  = 16'($urandom);
         host_run      = 1'($urandom_range(0, 1));
         #1;
         check_eq({tag, "_run_busy"},  busy,          1);
         check_eq({tag, "_run_pulse"}, fetch_start,   0);
         check_eq({tag, "_run_done"},  done,          0);
         check_eq({tag, "_run_rdy"},   host_wr_ready, 0);
         check_eq({tag, "_run_we"},    mem_we,        0);
         check_eq({tag, "_run_addr"},  mem_addr,      pc);
      end
      @(negedge clk);
      host_wr_valid = 1'b0;
      host_run      = 1'b0;
      #1;
      exp_res = exp_q.pop_front();
      check_eq({tag, "_end_busy"},   busy,       0);
      check_eq({tag, "_end_done"},   done,       1);
      check_eq({tag, "_end_to"},     timeout,    exp_res[CNT_W]);
      check_eq({tag, "_end_cycles"}, run_cycles, exp_res[CNT_W-1:0]);
      check_eq({tag, "_end_rdy"},    host_wr_ready, 1);
   endtask

   // Safety net against a hung run.
   initial begin
      #2000000;
      $display("FAIL global_timeout simulation exceeded time limit");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "global timeout");
   end

   // Main sequence.
   initial begin
      for (int a = 0; a < (1 << AW); a++) begin
         imem[a]    = 16'h0000;
         exp_mem[a] = 16'h0000;
      end
      rst = 1'b1; host_wr_valid = 1'b0; host_wr_addr = '0; host_wr_data = '0;
      host_run = 1'b0; pc_load = 1'b0; pc_load_val = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("rst_busy",   busy,          0);
      check_eq("rst_done",   done,          0);
      check_eq("rst_to",     timeout,       0);
      check_eq("rst_cycles", run_cycles,    0);
      check_eq("rst_pulse",  fetch_start,   0);
      check_eq("rst_rdy",    host_wr_ready, 1);
      check_eq("rst_we",     mem_we,        0);
      check_eq("rst_en",     mem_en,        1);

      // T1 load
      write_word(12'd0, 16'h0001);
      write_word(12'd1, 16'h0002);
      write_word(12'd2, 16'h0003);
      write_word(12'd3, 16'h000A);
      // T2 run
      run_prog("t2", 1'b0, 1'b0, '0, '0);
      check_eq("t2_cycles", run_cycles, 5);
      check_eq("t2_to",     timeout,    0);

      // T3 stale mask: stale read of the HALT at word 2 in the first RUN cycle
      write_word(12'd2, 16'h000A);
      idle_cycle();
      preload_pc(12'd2);
      run_prog("t3", 1'b0, 1'b0, '0, '0);
      check_eq("t3_cycles", run_cycles, 4);

      // T4 watchdog, with writes attempted during RUN
      for (int a = 0; a < 16; a++) write_word(12'(a), 16'h0100 | 16'(a % 8));
      run_prog("t4", 1'b1, 1'b0, '0, '0);
      check_eq("t4_cycles", run_cycles, 10);
      check_eq("t4_to",     timeout,    1);
      run_prog("t4_rerun", 1'b1, 1'b0, '0, '0);
      for (int a = 0; a < 16; a++) check_eq("t5_mem_kept", imem[a], exp_mem[a]);

      // T5 write accepted in DONE, then write+run in the same cycle
      write_word(12'd5, 16'h0003);
      idle_cycle();
      run_prog("t5_wr_run_idle", 1'b0, 1'b1, 12'd4, 16'h002A);
      run_prog("t5_wr_run_done", 1'b1, 1'b1, 12'd1, 16'h001A);
      check_eq("t5_mem_1", imem[1], 16'h001A);

      // T6 reset mid-run
      for (int a = 0; a < 4; a++) write_word(12'(a), 16'h0005);
      @(negedge clk); host_wr_valid = 1'b0; host_run = 1'b1;
      @(negedge clk); host_run = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("t6_busy",   busy,          0);
      check_eq("t6_done",   done,          0);
      check_eq("t6_cycles", run_cycles,    0);
      check_eq("t6_pulse",  fetch_start,   0);
      check_eq("t6_rdy",    host_wr_ready, 1);

      // Randomized programs
      for (int it = 0; it < 30; it++) begin
         int n;
         n = $urandom_range(0, 4);
         for (int k = 0; k < n; k++) write_word(12'($urandom_range(0, 11)), rand_word());
         if ($urandom_range(0, 3) == 0) preload_pc(12'($urandom_range(0, 11)));
         run_prog("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  12'($urandom_range(0, 11)), rand_word());
      end
      for (int a = 0; a < 16; a++) check_eq("final_mem", imem[a], exp_mem[a]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
